// File: rtl/mips_mem_responder.sv
// Word-organised MIPS data/instruction memory behind a req/ack handshake with
// configurable wait states. Byte lanes are enabled by defining MIPS_MEM_BYTE_ACCESS_EN.
module mips_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: req is sampled only in IDLE; the initiator holds req and its
  // inputs until it sees the one-cycle ack pulse, and rdata/err are
  // meaningful only while ack is high. req still high after ack is a new request.

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic        we_q;
  logic        size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic             misaligned;
  logic             byte_rej;
  logic             bad;
  logic             mem_we;
  logic [31:0]      cur_word;
  logic [31:0]      rd_val;
  logic [31:0]      wr_word;

`ifdef MIPS_MEM_BYTE_ACCESS_EN
  logic [4:0]  lane_sh;
  logic [7:0]  byte_val;
  logic [31:0] byte_mask;
  logic [31:0] byte_word;
`endif

  always_comb begin
    idx          = addr_q[IDX_W+1:2];
    out_of_range = (addr_q >> (IDX_W + 2)) != 32'd0;
    misaligned   = !size_q && (addr_q[1:0] != 2'b00);
    cur_word     = mem_q[idx];
`ifdef MIPS_MEM_BYTE_ACCESS_EN
    // Big-endian: lane 0 is bits 31:24, so the shift is (3 - addr[1:0]) * 8.
    lane_sh   = {~addr_q[1:0], 3'b000};
    byte_val  = 8'(cur_word >> lane_sh);
    byte_mask = 32'h0000_00FF << lane_sh;
    byte_word = (cur_word & ~byte_mask) | ({24'd0, wdata_q[7:0]} << lane_sh);
    byte_rej  = 1'b0;
    rd_val    = size_q ? {24'd0, byte_val} : cur_word;
    wr_word   = size_q ? byte_word : wdata_q;
`else
    byte_rej  = size_q;
    rd_val    = cur_word;
    wr_word   = wdata_q;
`endif
    bad    = out_of_range || misaligned || byte_rej;
    mem_we = (state_q == S_ACCESS) && we_q && !bad;
  end

  // Memory array has no reset: contents survive reset by design.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            wcnt_q  <= WAIT_INIT;
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q <= 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          err_q   <= bad;
          rdata_q <= (bad || we_q) ? 32'd0 : rd_val;
          ack_q   <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomised bench for mips_mem_responder against a byte-array memory model.
// Two instances: default wait states (d=0) and WAIT_CYCLES=0 (d=1).
module tb_mips_mem_responder;

  localparam int DEPTH = 1024;
  localparam int NBYTES = DEPTH * 4;
`ifdef MIPS_MEM_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        req_s   [2];
  logic        we_s    [2];
  logic        size_s  [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ack_s   [2];
  logic        err_s   [2];
  logic [1:0]  dbg_s   [2];

  int wait_cfg [2] = '{2, 0};

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]),
    .err(err_s[0]), .dbg_state(dbg_s[0])
  );

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]),
    .err(err_s[1]), .dbg_state(dbg_s[1])
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem_b [2][NBYTES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: memory as a flat big-endian byte array.
  function automatic void model(input int d, input bit w, input bit sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output bit e);
    int base;
    int ai;
    e = (a >= 32'(NBYTES)) || (!sz && (a % 4 != 0)) || (sz && !BYTE_EN);
    rd = 32'd0;
    if (e) return;
    ai = int'(a);
    base = ai - (ai % 4);
    if (w) begin
      if (sz) mem_b[d][ai] = wd[7:0];
      else for (int k = 0; k < 4; k++) mem_b[d][base + k] = wd[31 - 8*k -: 8];
    end else if (sz) begin
      rd = {24'd0, mem_b[d][ai]};
    end else begin
      rd = {mem_b[d][base], mem_b[d][base+1], mem_b[d][base+2], mem_b[d][base+3]};
    end
  endfunction

  // driver: one full transaction, then checks latency, err and rdata
  task automatic txn(input int d, input bit w, input bit sz, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    logic [31:0] erd;
    bit          eerr;
    int          cyc;
    @(posedge clock); #1;
    check({tag, "_ack_idle"}, {31'd0, ack_s[d]}, 32'd0);
    req_s[d] = 1'b1; we_s[d] = w; size_s[d] = sz; addr_s[d] = a; wdata_s[d] = wd;
    model(d, w, sz, a, wd, erd, eerr);
    exp_q.push_back(erd);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 1) begin
        // scribble the inputs while busy; the latched copies must be used
        we_s[d] = $urandom_range(0, 1); size_s[d] = $urandom_range(0, 1);
        addr_s[d] = $urandom; wdata_s[d] = $urandom;
      end
    end while (!ack_s[d] && cyc < 40);
    req_s[d] = 1'b0;
    check({tag, "_lat"}, cyc, wait_cfg[d] + 2);
    check({tag, "_err"}, {31'd0, err_s[d]}, {31'd0, eerr});
    check({tag, "_rdata"}, rdata_s[d], exp_q.pop_front());
  endtask

  initial begin
    int acks;
    int cyc;
    int first_ack;
    int second_ack;
    logic [31:0] a;
    foreach (mem_b[d, i]) mem_b[d][i] = 8'd0;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 0; we_s[d] = 0; size_s[d] = 0; addr_s[d] = 0; wdata_s[d] = 0;
    end

    // reset defaults
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_ack", {31'd0, ack_s[0]}, 32'd0);
    check("rst_err", {31'd0, err_s[0]}, 32'd0);
    check("rst_rdata", rdata_s[0], 32'd0);
    acks = 0;
    repeat (10) begin
      @(posedge clock); #1;
      acks += int'(ack_s[0]) + int'(ack_s[1]);
    end
    check("idle_no_ack", acks, 0);

    // word write then read
    txn(0, 1, 0, 32'h40, 32'hDEADBEEF, "wr40");
    txn(0, 0, 0, 32'h40, 32'h0, "rd40");

    // byte lanes, or their rejection when compiled out
`ifdef MIPS_MEM_BYTE_ACCESS_EN
    txn(0, 1, 1, 32'h41, 32'h12, "bwr41");
    txn(0, 0, 0, 32'h40, 32'h0, "rd40_lane");
    txn(0, 0, 1, 32'h43, 32'h0, "brd43");
`else
    txn(0, 1, 1, 32'h40, 32'h55, "bwr40_rej");
    txn(0, 0, 0, 32'h40, 32'h0, "rd40_kept");
`endif

    // error cases
    txn(0, 0, 0, 32'h42, 32'h0, "rd42_mis");
    txn(0, 1, 0, 32'h0, 32'h13572468, "wr0");
    txn(0, 1, 0, 32'h1000, 32'hFFFFFFFF, "wr1000_oor");
    txn(0, 0, 0, 32'h0, 32'h0, "rd0_kept");

    // reset during WAIT abandons the write
    txn(0, 1, 0, 32'h80, 32'h0, "wr80_zero");
    @(posedge clock); #1;
    req_s[0] = 1; we_s[0] = 1; size_s[0] = 0; addr_s[0] = 32'h80; wdata_s[0] = 32'hCAFEF00D;
    @(posedge clock); #1;
    reset = 1'b1;
    req_s[0] = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_ack", {31'd0, ack_s[0]}, 32'd0);
    check("midrst_rdata", rdata_s[0], 32'd0);
    acks = 0;
    repeat (10) begin
      @(posedge clock); #1;
      acks += int'(ack_s[0]);
    end
    check("midrst_no_ack", acks, 0);
    txn(0, 0, 0, 32'h80, 32'h0, "rd80_after_rst");

    // zero wait states, back-to-back reads with req held high
    txn(1, 1, 0, 32'h20, 32'h11111111, "w0_wr20");
    txn(1, 1, 0, 32'h24, 32'h22222222, "w0_wr24");
    txn(1, 1, 0, 32'h3FC, 32'h0, "w0_wr3fc");
    @(posedge clock); #1;
    req_s[1] = 1; we_s[1] = 0; size_s[1] = 0; addr_s[1] = 32'h20; wdata_s[1] = 0;
    cyc = 0; first_ack = -1; second_ack = -1;
    while (second_ack < 0 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 1 || (first_ack >= 0 && cyc == first_ack + 2)) begin
        we_s[1] = 1; addr_s[1] = 32'h3FC; wdata_s[1] = $urandom;
      end
      if (ack_s[1]) begin
        if (first_ack < 0) begin
          first_ack = cyc;
          check("b2b_rd1", rdata_s[1], 32'h11111111);
          we_s[1] = 0; addr_s[1] = 32'h24;
        end else begin
          second_ack = cyc;
          check("b2b_rd2", rdata_s[1], 32'h22222222);
          req_s[1] = 0;
        end
      end
    end
    req_s[1] = 0;
    check("b2b_ack1_cyc", first_ack, 2);
    check("b2b_ack2_cyc", second_ack, 5);
    txn(1, 0, 0, 32'h3FC, 32'h0, "w0_rd3fc_kept");

    // randomised traffic on a pre-written pool of words
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        txn(d, 1, 0, 32'h100 + 32'(4 * i), $urandom, "pool_init");
    for (int n = 0; n < 60; n++) begin
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
          $urandom, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
